axis_traffic_sink: RTL and testbench
====================================

Name: axis_traffic_sink

Overview:
Synthesizable AXI-Stream packet sink and checker. It is the receiving endpoint paired with the traffic generator at each mesh node. It applies pseudo-random backpressure, validates packet routing, ordering and handshake rules, and accumulates per-source packet counts and end-to-end latency statistics. Bench harnesses and on-chip NoC test systems instantiate one per mesh output port.

Parameters:
TDATA_WIDTH, 32, data width; even, >=8; H = TDATA_WIDTH/2
TDEST_WIDTH, 2, destination field width
TID_WIDTH, 2, source id width; 2**TID_WIDTH sources tracked
TDEST, 0, this endpoint's address; expected tdest
COUNT_WIDTH, 16, width of packet counters (saturating)
READY_SEED, 16'hACE1, nonzero reset value of the 16-bit backpressure LFSR
LAT_SUM_WIDTH, 32, width of latency accumulator (saturating)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = accept traffic; 0 = tready held low
ready_load  in  16  backpressure threshold; FFFF = always ready, 0 = never ready
ticks  in  H  free-running timestamp shared with generators
axis_in_tvalid  in  1  stream valid
axis_in_tready  out  1  stream ready (registered)
axis_in_tdata  in  TDATA_WIDTH  stream data
axis_in_tlast  in  1  last beat of packet
axis_in_tid  in  TID_WIDTH  source id
axis_in_tdest  in  TDEST_WIDTH  destination
recv_packets  out  COUNT_WIDTH x 2**TID_WIDTH  completed packets per source id
max_latency  out  H  largest head-beat latency seen
latency_sum  out  LAT_SUM_WIDTH  sum of head-beat latencies
error_code  out  4  sticky error bits
error  out  1  OR of error_code

Behaviour:
- Packet format: head beat tdata = {seq[H-1:0], timestamp[H-1:0]}; following beats are payload and are not checked; tlast ends the packet. A one-beat packet is both head and tail.
- Reset (async assert, sync-safe release): tready=0, LFSR=READY_SEED, all counters, latency outputs and error bits = 0, expected_seq[*]=0, FSM=S_HEAD.
- Backpressure: the 16-bit Galois LFSR (taps 16,14,13,11) advances every cycle after reset. Next-cycle tready = enable & (lfsr <= ready_load). The registered value lands one cycle later.
- Beat accepted iff tvalid & tready on a rising clk.
- FSM S_HEAD: on an accepted beat, latch tid as cur_tid, compute latency, check tdest and seq. If tlast=0, go to S_BODY. If tlast=1, stay in S_HEAD and count the packet.
- FSM S_BODY: on an accepted beat with tlast=1, count the packet and go to S_HEAD.
- Latency = (ticks - timestamp) mod 2**H, evaluated in the head-accept cycle. max_latency updates if greater. latency_sum adds and saturates at all-ones.
- recv_packets[cur_tid] increments on tail acceptance and saturates at all-ones.
- Sequence check: head seq != expected_seq[tid] sets error_code[2]. expected_seq[tid] := seq+1 mod 2**H in either case (resync). Wrap from all-ones to 0 is legal.
- error_code[0]: head tdest != TDEST.
- error_code[1]: tid differs from cur_tid on any accepted S_BODY beat.
- error_code[3]: handshake violation. tvalid was high and tready low in cycle N, then in cycle N+1 tvalid is low or tdata/tlast/tid/tdest changed.
- Error bits are sticky until reset. Packets with errors are still counted. Outputs update one cycle after the accepting edge.
- enable falling mid-packet: tready drops after the register delay, FSM state is held, the packet resumes on re-enable.
- Reset mid-packet: returns to S_HEAD; the next beat is treated as a head.

Test Plan:
- ready_load=FFFF, enable=1, source tid=1 sends 4 one-beat packets seq 0..3 to TDEST, timestamp=ticks-5 -> recv_packets[1]=4, max_latency=5, latency_sum=20, error=0.
- 3-beat packet from tid=2, ready_load=8000 -> tready toggles per LFSR, exactly 1 count in recv_packets[2], FSM back in S_HEAD after tlast.
- Head with tdest=TDEST+1 -> error_code=0001 one cycle after accept; recv_packets still increments.
- tid=0 sends seq 0,1,3 -> error_code[2] set on third head; next seq 4 raises no new error (expected resynced to 4).
- tvalid high with tready held low by ready_load=0, tdata changed next cycle -> error_code[3]=1; mid-packet tid change -> error_code[1]=1.
- rst_n asserted asynchronously in S_BODY -> outputs 0 immediately; after release, a one-beat packet seq 0 is counted cleanly with error=0.

Source files
------------

// File: rtl/axis_traffic_sink.sv
// AXI-Stream packet sink/checker: LFSR-driven backpressure, routing/order/handshake
// checks, per-source packet counts and head-beat latency statistics.
`timescale 1ns/1ps
module axis_traffic_sink #(
  parameter int unsigned TDATA_WIDTH   = 32,
  parameter int unsigned TDEST_WIDTH   = 2,
  parameter int unsigned TID_WIDTH     = 2,
  parameter int unsigned TDEST         = 0,
  parameter int unsigned COUNT_WIDTH   = 16,
  parameter logic [15:0] READY_SEED    = 16'hACE1,
  parameter int unsigned LAT_SUM_WIDTH = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          enable,
  input  logic [15:0]                                   ready_load,
  input  logic [TDATA_WIDTH/2-1:0]                      ticks,
  input  logic                                          axis_in_tvalid,
  output logic                                          axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]                        axis_in_tdata,
  input  logic                                          axis_in_tlast,
  input  logic [TID_WIDTH-1:0]                          axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]                        axis_in_tdest,
  output logic [2**TID_WIDTH-1:0][COUNT_WIDTH-1:0]      recv_packets,
  output logic [TDATA_WIDTH/2-1:0]                      max_latency,
  output logic [LAT_SUM_WIDTH-1:0]                      latency_sum,
  output logic [3:0]                                    error_code,
  output logic                                          error
);

  localparam int unsigned H       = TDATA_WIDTH / 2;
  localparam int unsigned NUM_SRC = 2 ** TID_WIDTH;
  localparam int unsigned SUMW    = LAT_SUM_WIDTH + 1;
  localparam int unsigned PW      = TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH;

  typedef enum logic {S_HEAD, S_BODY} state_t;

  state_t                         state, state_next;
  logic [15:0]                    lfsr, lfsr_next_c;
  logic [TID_WIDTH-1:0]           cur_tid, tail_tid_c;
  logic [NUM_SRC-1:0][H-1:0]      expected_seq;
  logic                           prev_stall;
  logic [PW-1:0]                  prev_payload, payload_c;
  logic                           accept_c, head_c, tail_c;
  logic [3:0]                     err_new_c;
  logic [H-1:0]                   seq_c, ts_c, latency_c;
  logic [SUMW-1:0]                sum_ext_c;

  // Galois LFSR, taps 16,14,13,11
  assign lfsr_next_c = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};

  assign accept_c  = axis_in_tvalid & axis_in_tready;
  assign seq_c     = axis_in_tdata[TDATA_WIDTH-1:H];
  assign ts_c      = axis_in_tdata[H-1:0];
  assign latency_c = ticks - ts_c;
  assign sum_ext_c = {1'b0, latency_sum} + SUMW'(latency_c);
  assign payload_c = {axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HEAD;
    else        state <= state_next;
  end

  // Packet framing plus detection of new error conditions
  always_comb begin
    state_next = state;
    head_c     = 1'b0;
    tail_c     = 1'b0;
    tail_tid_c = cur_tid;
    err_new_c  = '0;
    case (state)
      S_HEAD: begin
        if (accept_c) begin
          head_c     = 1'b1;
          tail_tid_c = axis_in_tid;
          if (axis_in_tlast) tail_c     = 1'b1;
          else               state_next = S_BODY;
        end
      end
      S_BODY: begin
        if (accept_c) begin
          if (axis_in_tid != cur_tid) err_new_c[1] = 1'b1;
          if (axis_in_tlast) begin
            tail_c     = 1'b1;
            state_next = S_HEAD;
          end
        end
      end
      default: state_next = S_HEAD;
    endcase
    if (head_c && (axis_in_tdest != TDEST_WIDTH'(TDEST))) err_new_c[0] = 1'b1;
    if (head_c && (seq_c != expected_seq[axis_in_tid]))   err_new_c[2] = 1'b1;
    if (prev_stall && (!axis_in_tvalid || (payload_c != prev_payload))) err_new_c[3] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr           <= READY_SEED;
      axis_in_tready <= 1'b0;
      cur_tid        <= '0;
      expected_seq   <= '0;
      prev_stall     <= 1'b0;
      prev_payload   <= '0;
      recv_packets   <= '0;
      max_latency    <= '0;
      latency_sum    <= '0;
      error_code     <= '0;
      error          <= 1'b0;
    end else begin
      lfsr           <= lfsr_next_c;
      axis_in_tready <= enable & (lfsr <= ready_load);
      prev_stall     <= axis_in_tvalid & ~axis_in_tready;
      prev_payload   <= payload_c;
      error_code     <= error_code | err_new_c;
      error          <= |(error_code | err_new_c);
      if (head_c) begin
        cur_tid                    <= axis_in_tid;
        expected_seq[axis_in_tid]  <= seq_c + H'(1);
        if (latency_c > max_latency) max_latency <= latency_c;
        latency_sum <= sum_ext_c[LAT_SUM_WIDTH] ? '1 : sum_ext_c[LAT_SUM_WIDTH-1:0];
      end
      // Saturating per-source packet counter
      if (tail_c && (recv_packets[tail_tid_c] != '1))
        recv_packets[tail_tid_c] <= recv_packets[tail_tid_c] + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_traffic_sink.sv
// Directed self-checking bench for axis_traffic_sink: table-driven one-beat packets
// plus hand-written multi-cycle sequences (backpressure, saturation, errors, reset).
`timescale 1ns/1ps
module tb_axis_traffic_sink;

  localparam int unsigned TDW     = 32;
  localparam int unsigned H       = 16;
  localparam int unsigned TDESTW  = 2;
  localparam int unsigned TIDW    = 2;
  localparam int unsigned CW      = 3;
  localparam int unsigned LSW     = 18;
  localparam int unsigned MY_DEST = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      enable = 1'b1;
  logic [15:0]               ready_load = 16'hFFFF;
  logic [H-1:0]              ticks = '0;
  logic                      tvalid = 1'b0;
  logic                      tready;
  logic [TDW-1:0]            tdata = '0;
  logic                      tlast = 1'b0;
  logic [TIDW-1:0]           tid = '0;
  logic [TDESTW-1:0]         tdest = '0;
  logic [3:0][CW-1:0]        recv_packets;
  logic [H-1:0]              max_latency;
  logic [LSW-1:0]            latency_sum;
  logic [3:0]                error_code;
  logic                      error;

  int n_checks = 0;
  int n_fail   = 0;

  axis_traffic_sink #(
    .TDATA_WIDTH(TDW), .TDEST_WIDTH(TDESTW), .TID_WIDTH(TIDW), .TDEST(MY_DEST),
    .COUNT_WIDTH(CW), .READY_SEED(16'hACE1), .LAT_SUM_WIDTH(LSW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ready_load(ready_load), .ticks(ticks),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tdata(tdata),
    .axis_in_tlast(tlast), .axis_in_tid(tid), .axis_in_tdest(tdest),
    .recv_packets(recv_packets), .max_latency(max_latency), .latency_sum(latency_sum),
    .error_code(error_code), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    tvalid = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
  endtask

  // Presents one beat at a negedge, holds it until accepted, returns at the next negedge
  task automatic send_beat(input logic [1:0] b_tid, input logic [1:0] b_dest,
                           input logic [15:0] b_seq, input logic [15:0] b_ts,
                           input logic [15:0] b_ticks, input logic b_last);
    int waited = 0;
    tid    = b_tid;
    tdest  = b_dest;
    tdata  = {b_seq, b_ts};
    tlast  = b_last;
    ticks  = b_ticks;
    tvalid = 1'b1;
    while (tready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got tready=%b, expected 1 within 200 cycles", tready);
      tvalid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      tvalid = 1'b0;
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] s;
    s = x >> 1;
    return x[0] ? (s ^ 16'hB400) : s;
  endfunction

  typedef struct {
    logic [1:0]     tid;
    logic [1:0]     dest;
    logic [15:0]    seq;
    logic [15:0]    ts;
    logic [15:0]    tk;
    logic [CW-1:0]  exp_cnt;
    logic [3:0]     exp_err;
    logic [15:0]    exp_max;
    logic [LSW-1:0] exp_sum;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [15:0] l;
    int exp_cnt;
    int exp_sum;

    // One-beat packets in a single reset epoch; counts, errors and latency stats accumulate
    vecs[0] = '{2'd1, 2'd2, 16'd0, 16'd95,     16'd100, 3'd1, 4'h0, 16'd5, 18'd5};
    vecs[1] = '{2'd1, 2'd2, 16'd1, 16'd95,     16'd100, 3'd2, 4'h0, 16'd5, 18'd10};
    vecs[2] = '{2'd1, 2'd2, 16'd2, 16'd95,     16'd100, 3'd3, 4'h0, 16'd5, 18'd15};
    vecs[3] = '{2'd1, 2'd2, 16'd3, 16'd95,     16'd100, 3'd4, 4'h0, 16'd5, 18'd20};
    vecs[4] = '{2'd0, 2'd2, 16'd0, 16'd16,     16'd18,  3'd1, 4'h0, 16'd5, 18'd22};
    vecs[5] = '{2'd0, 2'd2, 16'd1, 16'hFFFE,   16'd3,   3'd2, 4'h0, 16'd5, 18'd27};
    vecs[6] = '{2'd0, 2'd2, 16'd3, 16'd200,    16'd209, 3'd3, 4'h4, 16'd9, 18'd36};
    vecs[7] = '{2'd0, 2'd2, 16'd4, 16'd300,    16'd301, 3'd4, 4'h4, 16'd9, 18'd37};
    vecs[8] = '{2'd3, 2'd3, 16'd0, 16'd0,      16'd4,   3'd1, 4'h5, 16'd9, 18'd41};

    // Reset state
    enable = 1'b1;
    ready_load = 16'hFFFF;
    do_reset();
    check("reset_tready", 64'(tready), 64'd0);
    check("reset_recv", 64'(recv_packets), 64'd0);
    check("reset_max", 64'(max_latency), 64'd0);
    check("reset_sum", 64'(latency_sum), 64'd0);
    check("reset_err", 64'({error, error_code}), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send_beat(vecs[i].tid, vecs[i].dest, vecs[i].seq, vecs[i].ts, vecs[i].tk, 1'b1);
      check($sformatf("vec%0d_cnt", i), 64'(recv_packets[vecs[i].tid]), 64'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_errcode", i), 64'(error_code), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_error", i), 64'(error), 64'(vecs[i].exp_err != 4'h0));
      check($sformatf("vec%0d_max", i), 64'(max_latency), 64'(vecs[i].exp_max));
      check($sformatf("vec%0d_sum", i), 64'(latency_sum), 64'(vecs[i].exp_sum));
    end

    // LFSR backpressure pattern, then a 3-beat packet under that backpressure
    ready_load = 16'h8000;
    do_reset();
    l = 16'hACE1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("lfsr_tready%0d", k), 64'(tready), 64'(l <= 16'h8000));
      l = lfsr_step(l);
    end
    send_beat(2'd2, 2'd2, 16'd0, 16'd50, 16'd53, 1'b0);
    send_beat(2'd2, 2'd2, 16'h1234, 16'h5678, 16'd60, 1'b0);
    check("body_cnt_before_tail", 64'(recv_packets[2]), 64'd0);
    send_beat(2'd2, 2'd2, 16'hABCD, 16'hEF01, 16'd70, 1'b1);
    check("multi_cnt", 64'(recv_packets[2]), 64'd1);
    check("multi_max", 64'(max_latency), 64'd3);
    check("multi_sum", 64'(latency_sum), 64'd3);
    check("multi_err", 64'({error, error_code}), 64'd0);
    // A new head from another source proves the FSM returned to S_HEAD
    send_beat(2'd3, 2'd2, 16'd0, 16'd10, 16'd13, 1'b1);
    check("after_tail_cnt3", 64'(recv_packets[3]), 64'd1);
    check("after_tail_cnt2", 64'(recv_packets[2]), 64'd1);
    check("after_tail_err", 64'({error, error_code}), 64'd0);
    check("after_tail_sum", 64'(latency_sum), 64'd6);

    // Counter and latency-sum saturation
    ready_load = 16'hFFFF;
    do_reset();
    @(negedge clk);
    for (int n = 1; n <= 9; n++) begin
      send_beat(2'd2, 2'd2, 16'(n - 1), 16'd1, 16'd0, 1'b1);
      exp_cnt = (n > 7) ? 7 : n;
      exp_sum = (n * 65535 > 262143) ? 262143 : n * 65535;
      check($sformatf("sat_cnt%0d", n), 64'(recv_packets[2]), 64'(exp_cnt));
      check($sformatf("sat_sum%0d", n), 64'(latency_sum), 64'(exp_sum));
    end
    check("sat_max", 64'(max_latency), 64'hFFFF);
    check("sat_err", 64'({error, error_code}), 64'd0);

    // Handshake violation while stalled, then tid change mid-packet
    ready_load = 16'h0000;
    do_reset();
    tid = 2'd0; tdest = 2'd2; tlast = 1'b1; tdata = 32'h0000_1234;
    tvalid = 1'b1;
    @(negedge clk);
    check("stall_tready", 64'(tready), 64'd0);
    check("stall_legal_err", 64'(error_code), 64'd0);
    tdata = 32'h0000_5678;
    @(negedge clk);
    check("hs_errcode", 64'(error_code), 64'h8);
    check("hs_error", 64'(error), 64'd1);
    tvalid = 1'b0;
    ready_load = 16'hFFFF;
    repeat (2) @(negedge clk);
    send_beat(2'd0, 2'd2, 16'd0, 16'd0, 16'd0, 1'b0);
    send_beat(2'd1, 2'd2, 16'd0, 16'd0, 16'd0, 1'b1);
    check("tidchg_errcode", 64'(error_code), 64'hA);
    check("tidchg_cnt0", 64'(recv_packets[0]), 64'd1);
    check("tidchg_cnt1", 64'(recv_packets[1]), 64'd0);

    // Enable drop mid-packet, then asynchronous reset mid-packet
    do_reset();
    @(negedge clk);
    send_beat(2'd2, 2'd2, 16'd0, 16'd7, 16'd9, 1'b1);
    send_beat(2'd2, 2'd2, 16'd1, 16'd7, 16'd9, 1'b0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("disable_tready", 64'(tready), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    send_beat(2'd2, 2'd2, 16'h0, 16'h0, 16'd9, 1'b1);
    check("resume_cnt", 64'(recv_packets[2]), 64'd2);
    check("resume_err", 64'({error, error_code}), 64'd0);
    send_beat(2'd2, 2'd3, 16'd2, 16'd0, 16'd4, 1'b0);
    check("midpkt_baddest", 64'(error_code), 64'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_recv", 64'(recv_packets), 64'd0);
    check("async_rst_err", 64'({error, error_code}), 64'd0);
    check("async_rst_tready", 64'(tready), 64'd0);
    check("async_rst_lat", 64'({max_latency, latency_sum}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(2'd2, 2'd2, 16'd0, 16'd0, 16'd1, 1'b1);
    check("post_rst_cnt", 64'(recv_packets[2]), 64'd1);
    check("post_rst_err", 64'({error, error_code}), 64'd0);
    check("post_rst_sum", 64'(latency_sum), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
